class_search_engine: RTL and testbench

- Reads class hypervectors back out of the class vector generator, one 64-bit frame per cycle, and does associative search against a buffered query hypervector.
- Drives the generator's frame_id/frame_index address, XORs each returned frame with the matching query frame, and accumulates the Hamming distance per class.
- Reports the class with minimum distance.
- Sits between the encoder output (query stream) and the classification result consumer.

---
 rtl/class_search_engine.sv | 177 +++++++++++++++++
 tb/tb_class_search_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/class_search_engine.sv
// Associative search engine: buffers a query hypervector, streams every class
// hypervector from the generator, and reports the class at minimum Hamming distance.
module class_search_engine #(
  parameter int FRAME_W   = 64,
  parameter int N_FRAMES  = 3,
  parameter int N_CLASSES = 8,
  parameter int ID_W      = 3,
  parameter int IDX_W     = 2,
  parameter int DIST_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [FRAME_W-1:0] q_data,
  output logic [ID_W-1:0]    frame_id,
  output logic [IDX_W-1:0]   frame_index,
  input  logic [FRAME_W-1:0] class_vec_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_class,
  output logic [DIST_W-1:0]  res_dist,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [FRAME_W-1:0] r_qbuf [N_FRAMES];
  logic [IDX_W-1:0]   r_loadCnt;
  logic [DIST_W-1:0]  r_acc;
  logic [DIST_W-1:0]  r_bestDist;
  logic [ID_W-1:0]    r_bestClass;
  logic [ID_W-1:0]    r_frameId;
  logic [IDX_W-1:0]   r_frameIdx;
  logic [ID_W-1:0]    r_resClass;
  logic [DIST_W-1:0]  r_resDist;

  logic               w_loadFire;
  logic               w_lastLoad;
  logic               w_lastFrame;
  logic               w_lastClass;
  logic               w_resFire;
  logic [FRAME_W-1:0] w_qFrame;
  logic [DIST_W-1:0]  w_pc;
  logic [DIST_W-1:0]  w_d;
  logic               w_better;
  logic [DIST_W-1:0]  w_newBestDist;
  logic [ID_W-1:0]    w_newBestClass;

  function automatic logic [DIST_W-1:0] popcount(input logic [FRAME_W-1:0] v);
    logic [DIST_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      cnt = cnt + DIST_W'(v[i]);
    end
    return cnt;
  endfunction

  assign w_loadFire  = q_valid && (r_state == S_LOAD);
  assign w_lastLoad  = w_loadFire && (r_loadCnt == IDX_W'(N_FRAMES - 1));
  assign w_lastFrame = (r_frameIdx == IDX_W'(N_FRAMES - 1));
  assign w_lastClass = (r_frameId == ID_W'(N_CLASSES - 1));
  assign w_resFire   = (r_state == S_DONE) && res_ready;

  // Guarded mux so an unused index value can never address past the buffer.
  always_comb begin
    w_qFrame = '0;
    for (int f = 0; f < N_FRAMES; f++) begin
      if (r_frameIdx == IDX_W'(f)) begin
        w_qFrame = r_qbuf[f];
      end
    end
  end

  assign w_pc           = popcount(class_vec_in ^ w_qFrame);
  assign w_d            = r_acc + w_pc;
  assign w_better       = (w_d < r_bestDist);
  assign w_newBestDist  = w_better ? w_d : r_bestDist;
  assign w_newBestClass = w_better ? r_frameId : r_bestClass;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_LOAD:   if (w_lastLoad) w_nextState = S_SEARCH;
      S_SEARCH: if (w_lastFrame && w_lastClass) w_nextState = S_DONE;
      S_DONE:   if (w_resFire) w_nextState = S_LOAD;
      default:  w_nextState = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loadCnt   <= '0;
      r_acc       <= '0;
      r_bestDist  <= '0;
      r_bestClass <= '0;
      r_frameId   <= '0;
      r_frameIdx  <= '0;
      r_resClass  <= '0;
      r_resDist   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_loadFire) begin
            for (int f = 0; f < N_FRAMES; f++) begin
              if (r_loadCnt == IDX_W'(f)) begin
                r_qbuf[f] <= q_data;
              end
            end
            if (w_lastLoad) begin
              r_loadCnt   <= '0;
              r_acc       <= '0;
              r_bestDist  <= '1;
              r_bestClass <= '0;
              r_frameId   <= '0;
              r_frameIdx  <= '0;
            end else begin
              r_loadCnt <= r_loadCnt + 1'b1;
            end
          end
        end
        S_SEARCH: begin
          if (!w_lastFrame) begin
            r_acc      <= w_d;
            r_frameIdx <= r_frameIdx + 1'b1;
          end else begin
            // Strict less-than keeps the lower class index on ties.
            r_bestDist  <= w_newBestDist;
            r_bestClass <= w_newBestClass;
            r_acc       <= '0;
            r_frameIdx  <= '0;
            if (w_lastClass) begin
              r_resClass <= w_newBestClass;
              r_resDist  <= w_newBestDist;
            end else begin
              r_frameId <= r_frameId + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (w_resFire) begin
            r_frameId  <= '0;
            r_frameIdx <= '0;
          end
        end
        default: begin
          r_frameId  <= '0;
          r_frameIdx <= '0;
        end
      endcase
    end
  end

  assign q_ready     = (r_state == S_LOAD);
  assign res_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_LOAD);
  assign frame_id    = r_frameId;
  assign frame_index = r_frameIdx;
  assign res_class   = r_resClass;
  assign res_dist    = r_resDist;

endmodule

// File: tb/tb_class_search_engine.sv
// Self-checking bench for class_search_engine: behavioural class ROM, vector table
// with a scoreboard queue, plus hand-written backpressure and mid-search reset sequences.
module tb_class_search_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_valid;
  logic        q_ready;
  logic [63:0] q_data;
  logic [2:0]  frame_id;
  logic [1:0]  frame_index;
  logic [63:0] class_vec_in;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_class;
  logic [7:0]  res_dist;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] q0;
    logic [63:0] q1;
    logic [63:0] q2;
    bit          tieRom;
    int          gap;
    logic [2:0]  expClass;
    logic [7:0]  expDist;
  } vec_t;

  typedef struct {
    logic [2:0] c;
    logic [7:0] d;
  } exp_t;

  exp_t        sbQ[$];
  vec_t        vecs[8];
  bit          tieMode = 1'b0;
  logic [63:0] tieQ[3];

  always #5 clk = ~clk;

  class_search_engine dut (
    .clk         (clk),
    .rst         (rst),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .q_data      (q_data),
    .frame_id    (frame_id),
    .frame_index (frame_index),
    .class_vec_in(class_vec_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_class   (res_class),
    .res_dist    (res_dist),
    .busy        (busy)
  );

  // Class c: frame 0 has its low c bits set, frames 1 and 2 are zero;
  // tie mode makes classes 4 and 6 equal to the current query.
  always_comb begin
    class_vec_in = '0;
    if (tieMode && (frame_id == 3'd4 || frame_id == 3'd6)) begin
      if (frame_index == 2'd0) class_vec_in = tieQ[0];
      else if (frame_index == 2'd1) class_vec_in = tieQ[1];
      else if (frame_index == 2'd2) class_vec_in = tieQ[2];
    end else if (frame_index == 2'd0) begin
      class_vec_in = (64'd1 << frame_id) - 64'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic loadBeats(input vec_t v);
    logic [63:0] frames[3];
    frames[0] = v.q0;
    frames[1] = v.q1;
    frames[2] = v.q2;
    tieMode = v.tieRom;
    tieQ[0] = v.q0;
    tieQ[1] = v.q1;
    tieQ[2] = v.q2;
    for (int f = 0; f < 3; f++) begin
      if (f != 0) begin
        for (int g = 0; g < v.gap; g++) begin
          @(negedge clk);
          q_valid = 1'b0;
          q_data  = {$urandom(), $urandom()};
        end
      end
      @(negedge clk);
      q_valid = 1'b1;
      q_data  = frames[f];
      @(posedge clk);
      #1;
      q_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit timing, input string tag);
    exp_t e;
    int   sweepErr;
    e.c = v.expClass;
    e.d = v.expDist;
    sbQ.push_back(e);
    loadBeats(v);
    if (timing) begin
      sweepErr = 0;
      for (int k = 0; k < 24; k++) begin
        if (frame_id !== 3'(k / 3) || frame_index !== 2'(k % 3) ||
            res_valid !== 1'b0 || busy !== 1'b1 || q_ready !== 1'b0) begin
          sweepErr++;
        end
        @(posedge clk);
        #1;
      end
      checkOutput({tag, " address sweep errors"}, 64'(sweepErr), 64'd0);
      checkOutput({tag, " res_valid at T+25"}, 64'(res_valid), 64'd1);
    end else begin
      for (int i = 0; i < 60 && res_valid !== 1'b1; i++) begin
        @(posedge clk);
        #1;
      end
      checkOutput({tag, " res_valid seen"}, 64'(res_valid), 64'd1);
    end
    e = sbQ.pop_front();
    checkOutput({tag, " res_class"}, 64'(res_class), 64'(e.c));
    checkOutput({tag, " res_dist"}, 64'(res_dist), 64'(e.d));
  endtask

  task automatic finishHandshake(input string tag);
    logic [2:0] keepClass;
    logic [7:0] keepDist;
    keepClass = res_class;
    keepDist  = res_dist;
    @(posedge clk);
    #1;
    checkOutput({tag, " res_valid after handshake"}, 64'(res_valid), 64'd0);
    checkOutput({tag, " q_ready after handshake"}, 64'(q_ready), 64'd1);
    checkOutput({tag, " result held"}, {53'd0, res_class, res_dist}, {53'd0, keepClass, keepDist});
  endtask

  initial begin
    vec_t bp;
    int   holdErr;
    logic [2:0] holdClass;
    logic [7:0] holdDist;

    vecs[0] = '{q0: 64'h0, q1: 64'h0, q2: 64'h0, tieRom: 1'b0, gap: 0, expClass: 3'd0, expDist: 8'd0};
    vecs[1] = '{q0: 64'h7F, q1: 64'h0, q2: 64'h0, tieRom: 1'b0, gap: 0, expClass: 3'd7, expDist: 8'd0};
    vecs[2] = '{q0: '1, q1: '1, q2: '1, tieRom: 1'b0, gap: 0, expClass: 3'd7, expDist: 8'd185};
    vecs[3] = '{q0: 64'h5, q1: 64'h0, q2: 64'h0, tieRom: 1'b0, gap: 0, expClass: 3'd1, expDist: 8'd1};
    vecs[4] = '{q0: 64'h0, q1: 64'hFF, q2: 64'h0, tieRom: 1'b0, gap: 0, expClass: 3'd0, expDist: 8'd8};
    vecs[5] = '{q0: '1, q1: 64'h0, q2: 64'h0, tieRom: 1'b0, gap: 0, expClass: 3'd7, expDist: 8'd57};
    vecs[6] = '{q0: 64'hDEAD_BEEF, q1: 64'h1234, q2: 64'h8000_0000_0000_0001, tieRom: 1'b1, gap: 0,
                expClass: 3'd4, expDist: 8'd0};
    vecs[7] = '{q0: 64'h5, q1: 64'h0, q2: 64'h0, tieRom: 1'b0, gap: 2, expClass: 3'd1, expDist: 8'd1};

    rst       = 1'b1;
    q_valid   = 1'b0;
    q_data    = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset q_ready", 64'(q_ready), 64'd1);
    checkOutput("reset res_valid", 64'(res_valid), 64'd0);
    checkOutput("reset res_class/res_dist", {53'd0, res_class, res_dist}, 64'd0);
    checkOutput("reset frame addr", {59'd0, frame_id, frame_index}, 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i == 0, $sformatf("vec%0d", i));
      finishHandshake($sformatf("vec%0d", i));
    end

    // Backpressure in DONE with stray q_valid pulses.
    bp = vecs[3];
    res_ready = 1'b0;
    applyStimulus(bp, 1'b0, "bp");
    holdClass = res_class;
    holdDist  = res_dist;
    holdErr   = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      q_valid = 1'b1;
      q_data  = {$urandom(), $urandom()};
      @(posedge clk);
      #1;
      q_valid = 1'b0;
      if (res_valid !== 1'b1 || q_ready !== 1'b0 || res_class !== holdClass || res_dist !== holdDist) holdErr++;
    end
    checkOutput("bp hold errors", 64'(holdErr), 64'd0);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp release res_valid", 64'(res_valid), 64'd0);
    checkOutput("bp release q_ready", 64'(q_ready), 64'd1);
    applyStimulus(vecs[1], 1'b0, "after bp");
    finishHandshake("after bp");

    // Reset during SEARCH, then a fresh query must not see stale state.
    loadBeats(vecs[2]);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst q_ready", 64'(q_ready), 64'd1);
    checkOutput("midrst frame addr", {59'd0, frame_id, frame_index}, 64'd0);
    checkOutput("midrst res_valid", 64'(res_valid), 64'd0);
    checkOutput("midrst busy", 64'(busy), 64'd0);
    applyStimulus(vecs[4], 1'b1, "after midrst");
    finishHandshake("after midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
